// File: rtl/pe_pkg.sv
// Shared widths and feeder state encoding for the sub_pe datapath.
package pe_pkg;

    localparam int DATA_W = 8;
    localparam int CH_W   = 3;
    localparam int DEPTH  = 1 << CH_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/pair_regfile.sv
// Image/weight pair storage: one synchronous write port, one combinational read port.
module pair_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [AW-1:0]         raddr,
    output logic [2*DATA_W-1:0]   rdata
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sub_pe_feeder.sv
// Buffers a burst of image/weight pairs and replays them into sub_pe, one per clock.
module sub_pe_feeder
    import pe_pkg::*;
#(
    parameter int DATA_W = pe_pkg::DATA_W,
    parameter int CH_W   = pe_pkg::CH_W,
    parameter int DEPTH  = 1 << CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_channel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_img,
    input  logic [DATA_W-1:0] wr_weight,
    output logic              start,
    output logic [DATA_W-1:0] img,
    output logic [DATA_W-1:0] weight,
    output logic [CH_W-1:0]   channel,
    output logic              busy,
    output logic              done
);

    feeder_state_t state;
    logic [CH_W-1:0]     wr_cnt;
    logic [CH_W-1:0]     rd_cnt;
    logic [CH_W-1:0]     rd_addr;
    logic [2*DATA_W-1:0] rd_pair;
    logic                wr_en;
    logic                last_wr;

    assign wr_ready = (state == LOAD);
    assign wr_en    = wr_ready && wr_valid;
    assign last_wr  = wr_en && (wr_cnt == channel);

    // Registered outputs need the pair for the next cycle, so read one address ahead.
    always_comb begin
        rd_addr = '0;
        if (state == ISSUE) rd_addr = rd_cnt + 1'b1;
    end

    pair_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CH_W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_cnt),
        .wdata ({wr_img, wr_weight}),
        .raddr (rd_addr),
        .rdata (rd_pair)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            start   <= 1'b0;
            img     <= '0;
            weight  <= '0;
            channel <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        channel <= cfg_channel;
                        wr_cnt  <= '0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (last_wr) begin
                        rd_cnt <= '0;
                        start  <= 1'b1;
                        // A single-pair burst is still being written, so take it from the port.
                        if (channel == '0) begin
                            img    <= wr_img;
                            weight <= wr_weight;
                        end else begin
                            {img, weight} <= rd_pair;
                        end
                        state <= ISSUE;
                    end else if (wr_en) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    start <= 1'b0;
                    if (rd_cnt == channel) begin
                        img    <= '0;
                        weight <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rd_cnt        <= rd_cnt + 1'b1;
                        {img, weight} <= rd_pair;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_pe_feeder.sv
// Directed bench for sub_pe_feeder with a burst-level expectation queue.
module tb_sub_pe_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [2:0] cfg_channel;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_img;
    logic [7:0] wr_weight;
    logic       start;
    logic [7:0] img;
    logic [7:0] weight;
    logic [2:0] channel;
    logic       busy;
    logic       done;

    sub_pe_feeder #(.DATA_W(8), .CH_W(3)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_channel(cfg_channel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_img(wr_img), .wr_weight(wr_weight),
        .start(start), .img(img), .weight(weight), .channel(channel),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] img;
        logic [7:0] weight;
        logic       done;
    } exp_t;

    exp_t       q[$];
    logic       exp_busy = 1'b0;
    logic [2:0] exp_ch   = '0;
    bit         chk_en   = 1'b0;
    int         tests    = 0;
    int         fails    = 0;
    int         busy_cnt = 0;
    logic [7:0] img_v [8];
    logic [7:0] wt_v  [8];
    logic [7:0] first_img, first_wt;
    logic       first_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the burst-level expectation queue.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("start", start, e.start);
                check("img", img, e.img);
                check("weight", weight, e.weight);
                check("done", done, e.done);
                check("busy_burst", busy, 1);
                check("wr_ready_burst", wr_ready, 0);
            end else begin
                check("start_idle", start, 0);
                check("img_idle", img, 0);
                check("weight_idle", weight, 0);
                check("done_idle", done, 0);
                check("busy", busy, exp_busy);
                check("wr_ready", wr_ready, exp_busy);
            end
            check("channel", channel, exp_ch);
        end
    end

    always @(negedge clk) if (busy) busy_cnt++;

    task automatic cfg(input logic [2:0] ch);
        cfg_valid = 1'b1;
        cfg_channel = ch;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        exp_busy = 1'b1;
        exp_ch = ch;
    endtask

    task automatic push_burst(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.start = (i == 0);
            e.img = img_v[i];
            e.weight = wt_v[i];
            e.done = 1'b0;
            q.push_back(e);
        end
        e.start = 1'b0; e.img = '0; e.weight = '0; e.done = 1'b1;
        q.push_back(e);
        exp_busy = 1'b0;
    endtask

    task automatic write_pair(input logic [7:0] im, input logic [7:0] wt);
        wr_valid = 1'b1; wr_img = im; wr_weight = wt;
        @(posedge clk); #1;
        wr_valid = 1'b0; wr_img = '0; wr_weight = '0;
    endtask

    task automatic burst(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            if (stall && i > 0) begin
                @(posedge clk); #1;
            end
            write_pair(img_v[i], wt_v[i]);
        end
        push_burst(n);
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                first_img = img; first_wt = weight; first_start = start;
            end
        end while (!done && n < 30);
        check("done_seen", done, 1);
    endtask

    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_channel = 0; wr_valid = 0; wr_img = 0; wr_weight = 0;
        #12;
        check("rst_start", start, 0);
        check("rst_img", img, 0);
        check("rst_weight", weight, 0);
        check("rst_channel", channel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Burst of 4, back-to-back writes.
        img_v[0] = 3; img_v[1] = 4; img_v[2] = 5; img_v[3] = 6;
        wt_v[0]  = 1; wt_v[1]  = 2; wt_v[2]  = 3; wt_v[3]  = 4;
        cfg(3);
        burst(4, 0);
        wait_done(0, n);
        check("b4_first_start", first_start, 1);
        check("b4_first_img", first_img, 8'd3);
        check("b4_first_wt", first_wt, 8'd1);
        check("b4_done_latency", n, 5);
        @(posedge clk); #1;

        // Single pair, checks the write-through case and busy length.
        img_v[0] = 8'hFF; wt_v[0] = 8'h80;
        busy_cnt = 0;
        cfg(0);
        burst(1, 0);
        wait_done(0, n);
        check("b1_first_start", first_start, 1);
        check("b1_first_img", first_img, 8'hFF);
        check("b1_first_wt", first_wt, 8'h80);
        check("b1_done_latency", n, 2);
        @(negedge clk);
        check("b1_busy_cycles", busy_cnt, 3);
        @(posedge clk); #1;

        // Full depth with wr_valid gaps.
        for (int i = 0; i < 8; i++) begin
            img_v[i] = 8'h10 + 8'(i);
            wt_v[i]  = 8'hA0 - 8'(i * 3);
        end
        cfg(7);
        burst(8, 1);
        wait_done(0, n);
        check("b8_first_img", first_img, 8'h10);
        check("b8_done_latency", n, 9);
        @(posedge clk); #1;

        // Dropped cfg during LOAD and ISSUE, ignored write during ISSUE.
        img_v[0] = 10; img_v[1] = 11; img_v[2] = 12;
        wt_v[0]  = 20; wt_v[1]  = 21; wt_v[2]  = 22;
        cfg(2);
        cfg_valid = 1'b1; cfg_channel = 5;
        write_pair(img_v[0], wt_v[0]);
        cfg_valid = 1'b0;
        write_pair(img_v[1], wt_v[1]);
        write_pair(img_v[2], wt_v[2]);
        push_burst(3);
        cfg_valid = 1'b1; cfg_channel = 5;
        wr_valid = 1'b1; wr_img = 8'hEE; wr_weight = 8'hEE;
        @(negedge clk);
        @(posedge clk); #1;
        cfg_valid = 1'b0; wr_valid = 1'b0; wr_img = 0; wr_weight = 0;
        wait_done(1, n);
        check("drop_done_latency", n, 4);
        check("drop_channel", channel, 3'd2);
        @(posedge clk); #1;

        // Async reset on pair 1 of a 4-pair burst.
        img_v[0] = 8'h31; img_v[1] = 8'h32; img_v[2] = 8'h33; img_v[3] = 8'h34;
        wt_v[0]  = 8'h41; wt_v[1]  = 8'h42; wt_v[2]  = 8'h43; wt_v[3]  = 8'h44;
        cfg(3);
        burst(4, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_start", start, 0);
        check("arst_img", img, 0);
        check("arst_weight", weight, 0);
        check("arst_channel", channel, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_wr_ready", wr_ready, 0);
        q.delete();
        exp_busy = 1'b0;
        exp_ch = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        img_v[0] = 8'h5A; img_v[1] = 8'hC3;
        wt_v[0]  = 8'h01; wt_v[1]  = 8'h7F;
        cfg(1);
        burst(2, 0);
        wait_done(0, n);
        check("post_first_img", first_img, 8'h5A);
        check("post_done_latency", n, 3);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sub_pe_feeder.md
Name: sub_pe_feeder

Overview:
- Upstream stage of sub_pe.
- Accepts a burst of image/weight byte pairs from the on-chip buffer through a valid/ready write port, and stores them in a local register file.
- Replays the stored pairs into sub_pe, one pair per clock, with a one-cycle start pulse on the first pair.
- Forwards the configured channel value so sub_pe accumulates the matching number of products.

Parameters:
DATA_W, 8, width of img and weight samples
CH_W, 3, width of channel field; burst length = channel+1
DEPTH, 2**CH_W, register-file entries (max burst length, 8)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_valid  input  1  one-cycle request to begin a new burst; sampled only in IDLE
cfg_channel  input  CH_W  burst length minus 1, latched on accepted cfg_valid
wr_valid  input  1  write pair valid
wr_ready  output  1  feeder can accept a pair
wr_img  input  DATA_W  image byte to store
wr_weight  input  DATA_W  weight byte to store
start  output  1  one-cycle pulse, aligned with pair 0 on img/weight
img  output  DATA_W  image byte to sub_pe
weight  output  DATA_W  weight byte to sub_pe
channel  output  CH_W  latched cfg_channel, held stable for the whole burst
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last pair is issued

Behaviour:
- Clock/reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: all outputs 0 (wr_ready, start, img, weight, channel, busy, done); state IDLE; write and read counters 0. Register-file contents are not reset.
- All outputs are registered. The single exception is wr_ready, which is decoded from state.

State machine (IDLE, LOAD, ISSUE, DONE):
- IDLE:
  - wr_ready = 0.
  - On cfg_valid = 1: latch cfg_channel into channel, clear the write counter, go to LOAD.
- LOAD:
  - wr_ready = 1.
  - Each cycle with wr_valid & wr_ready stores the pair at buf[wr_cnt] and increments wr_cnt.
  - When the accepted write is number channel+1 (wr_cnt == channel), the next state is ISSUE.
  - cfg_valid is ignored in this state.
- ISSUE:
  - wr_ready = 0.
  - Runs for channel+1 consecutive cycles with rd_cnt = 0..channel.
  - img/weight = buf[rd_cnt]; start = 1 only when rd_cnt == 0.
  - After rd_cnt == channel, go to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - img/weight = 0, then go to IDLE.

Timing:
- If the last write is accepted on edge t, start and pair 0 are visible from edge t+1.
- Pair i is visible from edge t+1+i.
- done is visible from edge t+2+channel.
- busy falls together with done.
- Earliest accepted cfg_valid for the next burst is on the cycle after done.

Data rules:
- img/weight are 0 whenever not in ISSUE.
- channel holds its latched value until the next accepted cfg_valid; it persists through DONE and IDLE.

Boundary conditions:
- channel = 0: single-pair burst; start and the only pair appear on one cycle, then done.
- channel = 7: all 8 entries are used; the counters never wrap.
- wr_valid gaps in LOAD: the feeder waits indefinitely. There is no timeout.
- wr_valid while wr_ready = 0 is ignored. Data is not captured.
- cfg_valid in LOAD, ISSUE or DONE is dropped. It is not queued.
- cfg_valid and wr_valid on the same IDLE cycle: only cfg is taken. The write is not captured because wr_ready = 0.
- rst asserted mid-LOAD or mid-ISSUE: outputs go to 0 immediately (asynchronously), state returns to IDLE, and the partial burst is discarded. No done is generated.

Width:
- Counters are CH_W bits; compare against channel only. No arithmetic on the data path.

Decomposition:
- Shared package (pe_pkg):
  - DATA_W and CH_W constants.
  - Feeder state enum: IDLE = 2'd0, LOAD = 2'd1, ISSUE = 2'd2, DONE = 2'd3.
- One natural sub-module: pair_regfile.
  - DEPTH x (2*DATA_W) flop array.
  - One write port with enable and address.
  - One combinational read port by address.
- The FSM, counters and output registers stay in sub_pe_feeder.

Test Plan:
- Reset then idle: rst pulse, hold 5 cycles with no cfg.
  - Expect all outputs 0; wr_ready = 0.
- Burst of 4: cfg_valid with cfg_channel = 3; write pairs (3,1), (4,2), (5,3), (6,4) back-to-back.
  - Expect start = 1 with img = 3, weight = 1 on the cycle after the last write.
  - Then (4,2), (5,3), (6,4) on the following cycles.
  - done one cycle later; channel = 3 throughout.
- Single pair: cfg_channel = 0; write (0xFF, 0x80).
  - Expect one cycle with start = 1, img = 0xFF, weight = 0x80.
  - done next cycle; busy high for exactly 3 cycles.
- Full depth with stalls: cfg_channel = 7; 8 writes with wr_valid deasserted every other cycle.
  - Expect ISSUE to start only after the 8th accept.
  - 8 consecutive pairs in write order; no start on pairs 1..7.
- Dropped requests: cfg_valid pulsed during LOAD and during ISSUE with cfg_channel = 5 (original 2).
  - Expect channel to stay 2 and burst length 3.
  - wr_valid during ISSUE is not captured.
- Async reset mid-ISSUE: assert rst on pair 1 of a 4-pair burst.
  - Expect outputs 0 within the same cycle, no done, state IDLE.
  - A new cfg_channel = 1 burst afterwards runs correctly.
